// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: prefetch FIFO between Fetch and Decode with show-ahead head and redirect flush
module fetch_decode_queue #(
    parameter int WIDTH       = 8,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     validF,
    input  logic [INSTR_WIDTH-1:0]   InstrF,
    input  logic [WIDTH-1:0]         PCPlus4F,
    output logic                     enablePCFlipFlop,
    input  logic                     stallD,
    output logic                     validD,
    output logic [INSTR_WIDTH-1:0]   InstrD,
    output logic [WIDTH-1:0]         PCPlus4D,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0]       pc_mem    [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic                   full, empty, push, pop;

    always_comb begin
        full             = count == CNT_MAX;
        empty            = count == '0;
        push             = validF & ~full & ~flush;
        pop              = ~empty & ~stallD & ~flush;
        enablePCFlipFlop = ~full;
        validD           = ~empty;
        InstrD           = empty ? '0 : instr_mem[rd_ptr];
        PCPlus4D         = empty ? '0 : pc_mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset | flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= (push & ~pop) ? count + (AW+1)'(1) :
                      (pop & ~push) ? count - (AW+1)'(1) : count;
        end
    end

    // storage is not reset; empty entries are never observable
    always_ff @(posedge clk) begin
        if (push & ~reset) begin
            instr_mem[wr_ptr] <= InstrF;
            pc_mem[wr_ptr]    <= PCPlus4F;
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb_fetch_decode_queue: directed stimulus against a queue-based model plus literal head checks
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 0;
    logic        reset, flush, validF, stallD;
    logic [31:0] InstrF;
    logic [7:0]  PCPlus4F;
    logic        enablePCFlipFlop, validD;
    logic [31:0] InstrD;
    logic [7:0]  PCPlus4D;
    logic [2:0]  count;

    fetch_decode_queue #(.WIDTH(8), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush), .validF(validF),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F), .enablePCFlipFlop(enablePCFlipFlop),
        .stallD(stallD), .validD(validD), .InstrD(InstrD), .PCPlus4D(PCPlus4D),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [7:0]  p;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;
    bit   live = 0;
    bit   seen99 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (live) begin
            chk("m_valid", 32'(validD), 32'(q.size() != 0));
            chk("m_instr", InstrD, q.size() != 0 ? q[0].i : 32'h0);
            chk("m_pc", 32'(PCPlus4D), q.size() != 0 ? 32'(q[0].p) : 32'h0);
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_enpc", 32'(enablePCFlipFlop), 32'(q.size() != DEPTH));
            if (InstrD === 32'h99) seen99 = 1;
        end
    end

    task automatic drive(input bit r, input bit f, input bit v, input logic [31:0] ins,
                         input logic [7:0] pc, input bit s);
        bit do_pop, do_push;
        reset = r; flush = f; validF = v; InstrF = ins; PCPlus4F = pc; stallD = s;
        @(posedge clk);
        if (r | f) q.delete();
        else begin
            do_pop  = q.size() != 0 && !s;
            do_push = v && q.size() < DEPTH;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{ins, pc});
        end
        #1;
    endtask

    initial begin
        drive(1, 0, 1, 32'h77, 8'h1, 0);
        live = 1;
        drive(1, 0, 1, 32'h77, 8'h1, 0);
        chk("rst_valid", 32'(validD), 0);
        chk("rst_instr", InstrD, 0);
        chk("rst_pc", 32'(PCPlus4D), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_enpc", 32'(enablePCFlipFlop), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("idle_count", 32'(count), 0);

        drive(0, 0, 1, 32'hE3A00001, 8'h04, 0);
        chk("s1_valid", 32'(validD), 1);
        chk("s1_instr", InstrD, 32'hE3A00001);
        chk("s1_count", 32'(count), 1);
        drive(0, 0, 1, 32'hE3A01002, 8'h08, 0);
        chk("s2_instr", InstrD, 32'hE3A01002);
        chk("s2_pc", 32'(PCPlus4D), 8'h08);
        chk("s2_count", 32'(count), 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("s3_valid", 32'(validD), 0);

        for (int k = 1; k <= 5; k++) begin
            drive(0, 0, 1, 32'(k * 'h11), 8'(k * 4), 1);
            if (k == 3) chk("fill3_enpc", 32'(enablePCFlipFlop), 1);
            if (k >= 4) begin
                chk("fill_count", 32'(count), 4);
                chk("fill_enpc", 32'(enablePCFlipFlop), 0);
                chk("fill_head", InstrD, 32'h11);
            end
        end
        for (int k = 2; k <= 5; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk("drain_head", InstrD, k <= 4 ? 32'(k * 'h11) : 32'h0);
        end

        drive(0, 0, 1, 32'hA0, 8'h40, 1);
        drive(0, 0, 1, 32'hA1, 8'h41, 1);
        chk("pp_start", InstrD, 32'hA0);
        for (int j = 0; j < 10; j++) begin
            drive(0, 0, 1, 32'hA2 + 32'(j), 8'h42 + 8'(j), 0);
            chk("pp_count", 32'(count), 2);
            chk("pp_head", InstrD, 32'hA1 + 32'(j));
        end
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("pp_empty", 32'(count), 0);

        drive(0, 0, 1, 32'hC1, 8'h50, 1);
        drive(0, 0, 1, 32'hC2, 8'h54, 1);
        drive(0, 0, 1, 32'hC3, 8'h58, 1);
        chk("fl_pre", 32'(count), 3);
        drive(0, 1, 1, 32'h99, 8'h5C, 0);
        chk("fl_count", 32'(count), 0);
        chk("fl_valid", 32'(validD), 0);
        chk("fl_instr", InstrD, 0);
        chk("fl_enpc", 32'(enablePCFlipFlop), 1);
        drive(0, 0, 1, 32'hD1, 8'h60, 0);
        chk("fl_next", InstrD, 32'hD1);
        drive(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 4; k++) drive(0, 0, 1, 32'hE0 + 32'(k), 8'h70 + 8'(k), 1);
        chk("rs_full", 32'(count), 4);
        chk("rs_enpc0", 32'(enablePCFlipFlop), 0);
        drive(1, 0, 1, 32'hEE, 8'h7F, 1);
        chk("rs_count", 32'(count), 0);
        chk("rs_enpc1", 32'(enablePCFlipFlop), 1);
        drive(0, 0, 1, 32'hAB, 8'h80, 0);
        chk("rs_next", InstrD, 32'hAB);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("never99", 32'(seen99), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
